// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matmul_seq sequencer and its address generator.
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Wide enough for num_k products of two full-scale elements.
    function automatic int acc_width(input int data_w, input int dim_w);
        return 2 * data_w + dim_w;
    endfunction

    // Element index to byte offset: log2 of the element size in bytes.
    function automatic int byte_shift(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/matmul_agu.sv
// Combinational address generator: row-major byte addresses of A[i][k], B[k][j] and C[i][j].
module matmul_agu
    import matmul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 16
) (
    input  logic [DIM_W-1:0]  i,
    input  logic [DIM_W-1:0]  j,
    input  logic [DIM_W-1:0]  k,
    input  logic [DIM_W-1:0]  num_j,
    input  logic [DIM_W-1:0]  num_k,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_c,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [ADDR_W-1:0] addr_c
);
    localparam int SHIFT = byte_shift(DATA_W);

    logic [ADDR_W-1:0] idx_a, idx_b, idx_c;

    // Working in ADDR_W bits throughout gives the modulo-2^ADDR_W wrap for free.
    assign idx_a = ADDR_W'(i) * ADDR_W'(num_k) + ADDR_W'(k);
    assign idx_b = ADDR_W'(k) * ADDR_W'(num_j) + ADDR_W'(j);
    assign idx_c = ADDR_W'(i) * ADDR_W'(num_j) + ADDR_W'(j);

    assign addr_a = base_a + (idx_a << SHIFT);
    assign addr_b = base_b + (idx_b << SHIFT);
    assign addr_c = base_c + (idx_c << SHIFT);

endmodule

// File: rtl/matmul_seq.sv
// Sequencer/datapath for unsigned C = A x B: walks i/j/k, issues paired reads, writes each C once.
// Build option MATMUL_SAT_EN: saturate wr_data to DATA_W bits instead of wrapping.
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIM_W-1:0]  num_i,
    input  logic [DIM_W-1:0]  num_j,
    input  logic [DIM_W-1:0]  num_k,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_c,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready
);
    localparam int ACC_W  = acc_width(DATA_W, DIM_W);
    localparam int PROD_W = 2 * DATA_W;

    state_t             state;
    logic [DIM_W-1:0]   ni, nj, nk;
    logic [DIM_W-1:0]   i, j, k;
    logic [ADDR_W-1:0]  ba, bb, bc;
    logic [ACC_W-1:0]   acc;
    logic [PROD_W-1:0]  prod;

    matmul_agu #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_agu (
        .i      (i),
        .j      (j),
        .k      (k),
        .num_j  (nj),
        .num_k  (nk),
        .base_a (ba),
        .base_b (bb),
        .base_c (bc),
        .addr_a (rd_addr_a),
        .addr_b (rd_addr_b),
        .addr_c (wr_addr)
    );

    assign prod = PROD_W'(rd_data_a) * PROD_W'(rd_data_b);

`ifdef MATMUL_SAT_EN
    assign wr_data = (acc > ACC_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : acc[DATA_W-1:0];
`else
    assign wr_data = acc[DATA_W-1:0];
`endif

    // NOTE: every register here uses <= so all updates in a cycle see the pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the accumulator and latched operands are reset too, so addresses and wr_data read 0.
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            rd_en <= 1'b0;
            wr_en <= 1'b0;
            ni    <= '0;
            nj    <= '0;
            nk    <= '0;
            ba    <= '0;
            bb    <= '0;
            bc    <= '0;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ni   <= num_i;
                        nj   <= num_j;
                        nk   <= num_k;
                        ba   <= base_a;
                        bb   <= base_b;
                        bc   <= base_c;
                        i    <= '0;
                        j    <= '0;
                        k    <= '0;
                        acc  <= '0;
                        busy <= 1'b1;
                        if (num_i == '0 || num_j == '0 || num_k == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_FETCH;
                            rd_en <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    rd_en <= 1'b0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rd_valid) begin
                        acc <= acc + ACC_W'(prod);
                        if (k == nk - DIM_W'(1)) begin
                            k     <= '0;
                            wr_en <= 1'b1;
                            state <= ST_WRITE;
                        end else begin
                            k     <= k + DIM_W'(1);
                            rd_en <= 1'b1;
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_ready) begin
                        wr_en <= 1'b0;
                        acc   <= '0;
                        if (j != nj - DIM_W'(1)) begin
                            j     <= j + DIM_W'(1);
                            rd_en <= 1'b1;
                            state <= ST_FETCH;
                        end else begin
                            j <= '0;
                            if (i != ni - DIM_W'(1)) begin
                                i     <= i + DIM_W'(1);
                                rd_en <= 1'b1;
                                state <= ST_FETCH;
                            end else begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    // A zero-dimension product arrives here with done low and spends one extra cycle.
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_seq.sv
// Self-checking bench for matmul_seq: directed cases plus random products against a loop-nest model.
module tb_matmul_seq;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          reset;
    logic          start;
    logic [NW-1:0] num_i, num_j, num_k;
    logic [AW-1:0] base_a, base_b, base_c;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
    logic          rd_valid = 1'b0;
    logic [DW-1:0] rd_data_a = '0, rd_data_b = '0;
    logic [DW-1:0] wr_data;
    logic          wr_ready = 1'b0;

    matmul_seq #(.DATA_W(DW), .ADDR_W(AW), .DIM_W(NW)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_i     (num_i),
        .num_j     (num_j),
        .num_k     (num_k),
        .base_a    (base_a),
        .base_b    (base_b),
        .base_c    (base_c),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_valid  (rd_valid),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready)
    );

    // 8-bit instance for the overflow case.
    logic          start8;
    logic          busy8, done8, rd_en8, wr_en8;
    logic [AW-1:0] rd_addr_a8, rd_addr_b8, wr_addr8;
    logic          rd_valid8 = 1'b0;
    logic [7:0]    rd_data_a8 = '0, rd_data_b8 = '0;
    logic [7:0]    wr_data8;
    logic          wr_ready8;

    matmul_seq #(.DATA_W(8), .ADDR_W(AW), .DIM_W(NW)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .start     (start8),
        .num_i     (16'd1),
        .num_j     (16'd1),
        .num_k     (16'd2),
        .base_a    (32'h10),
        .base_b    (32'h20),
        .base_c    (32'h30),
        .busy      (busy8),
        .done      (done8),
        .rd_en     (rd_en8),
        .rd_addr_a (rd_addr_a8),
        .rd_addr_b (rd_addr_b8),
        .rd_valid  (rd_valid8),
        .rd_data_a (rd_data_a8),
        .rd_data_b (rd_data_b8),
        .wr_en     (wr_en8),
        .wr_addr   (wr_addr8),
        .wr_data   (wr_data8),
        .wr_ready  (wr_ready8)
    );
    assign wr_ready8 = 1'b1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word-addressed memory image and the reference model's expected traffic.
    logic [31:0] mem  [bit [31:0]];
    logic [7:0]  mem8 [bit [31:0]];

    typedef struct { logic [31:0] a; logic [31:0] b; } rd_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    rd_t exp_rd[$];
    wr_t exp_wr[$];
    rd_t rd_e;
    wr_t wr_e;

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic logic [7:0] rd_mem8(input logic [31:0] a);
        return mem8.exists(a) ? mem8[a] : 8'h0;
    endfunction

    function automatic logic [31:0] reduce32(input logic [79:0] v);
`ifdef MATMUL_SAT_EN
        return (v > 80'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
`else
        return v[31:0];
`endif
    endfunction

    task automatic build_model(input int ni, input int nj, input int nk,
                               input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] bc);
        logic [79:0] s;
        logic [31:0] aa, ab;
        for (int ii = 0; ii < ni; ii++) begin
            for (int jj = 0; jj < nj; jj++) begin
                s = '0;
                for (int kk = 0; kk < nk; kk++) begin
                    aa = ba + 32'((ii * nk + kk) * 4);
                    ab = bb + 32'((kk * nj + jj) * 4);
                    exp_rd.push_back('{aa, ab});
                    s = s + 80'(rd_mem(aa)) * 80'(rd_mem(ab));
                end
                exp_wr.push_back('{bc + 32'((ii * nj + jj) * 4), reduce32(s)});
            end
        end
    endtask

    task automatic load(input logic [31:0] base, input int idx, input logic [31:0] val);
        mem[base + 32'(idx * 4)] = val;
    endtask

    // Read responder: fixed latency, garbage data whenever rd_valid is low.
    int          rd_lat = 1;
    int          rd_seen = 0;
    bit          rsp_pend = 1'b0;
    int          rsp_cnt = 0;
    logic [31:0] rsp_a, rsp_b;

    always @(negedge clk) begin
        rd_valid  = 1'b0;
        rd_data_a = $urandom;
        rd_data_b = $urandom;
        if (rsp_pend) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                rsp_pend  = 1'b0;
                rd_valid  = 1'b1;
                rd_data_a = rd_mem(rsp_a);
                rd_data_b = rd_mem(rsp_b);
            end
        end
        if (rd_en) begin
            rd_seen++;
            check("rd_expected", 128'(exp_rd.size() != 0), 1);
            if (exp_rd.size() != 0) begin
                rd_e = exp_rd.pop_front();
                check("rd_addr_a", rd_addr_a, rd_e.a);
                check("rd_addr_b", rd_addr_b, rd_e.b);
            end
            rsp_pend = 1'b1;
            rsp_cnt  = rd_lat;
            rsp_a    = rd_addr_a;
            rsp_b    = rd_addr_b;
        end
    end

    // Write acceptor: stalls wr_stall cycles per element and checks the held request.
    int          wr_stall = 0;
    int          wr_seen = 0;
    int          st_cnt = 0;
    logic [31:0] hold_addr, hold_data;

    always @(negedge clk) begin
        if (wr_en) begin
            if (st_cnt == 0) begin
                hold_addr = wr_addr;
                hold_data = wr_data;
            end else begin
                check("wr_addr_stable", wr_addr, hold_addr);
                check("wr_data_stable", wr_data, hold_data);
            end
            if (st_cnt < wr_stall) begin
                wr_ready = 1'b0;
                st_cnt++;
            end else begin
                wr_ready = 1'b1;
                st_cnt   = 0;
                wr_seen++;
                check("wr_expected", 128'(exp_wr.size() != 0), 1);
                if (exp_wr.size() != 0) begin
                    wr_e = exp_wr.pop_front();
                    check("wr_addr", wr_addr, wr_e.addr);
                    check("wr_data", wr_data, wr_e.data);
                end
            end
        end else begin
            if (st_cnt != 0) begin
                check("wr_en_held", wr_en, 1);
                st_cnt = 0;
            end
            wr_ready = 1'b0;
        end
    end

    // 8-bit instance: 1-cycle memory and capture of its single write.
    bit          p8 = 1'b0;
    logic [31:0] h8a, h8b;
    logic [7:0]  got8 = '0;
    logic [31:0] got8_addr = '0;
    int          wr_cnt8 = 0;

    always @(negedge clk) begin
        rd_valid8 = 1'b0;
        rd_data_a8 = 8'($urandom);
        rd_data_b8 = 8'($urandom);
        if (p8) begin
            rd_valid8  = 1'b1;
            rd_data_a8 = rd_mem8(h8a);
            rd_data_b8 = rd_mem8(h8b);
            p8 = 1'b0;
        end
        if (rd_en8) begin
            p8  = 1'b1;
            h8a = rd_addr_a8;
            h8b = rd_addr_b8;
        end
        if (wr_en8) begin
            got8      = wr_data8;
            got8_addr = wr_addr8;
            wr_cnt8++;
        end
    end

    task automatic check_all_zero(input string name);
        check({name, "_busy"},  busy,      0);
        check({name, "_done"},  done,      0);
        check({name, "_rd_en"}, rd_en,     0);
        check({name, "_wr_en"}, wr_en,     0);
        check({name, "_addr_a"}, rd_addr_a, 0);
        check({name, "_addr_b"}, rd_addr_b, 0);
        check({name, "_wr_addr"}, wr_addr,  0);
        check({name, "_wr_data"}, wr_data,  0);
    endtask

    task automatic do_run(input string name, input int ni, input int nj, input int nk,
                          input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] bc,
                          input int lat, input int stall);
        int t0, dc, exp_dc;
        bit seen, zero;
        exp_rd.delete();
        exp_wr.delete();
        rd_lat   = lat;
        wr_stall = stall;
        rd_seen  = 0;
        wr_seen  = 0;
        zero     = (ni == 0 || nj == 0 || nk == 0);
        build_model(ni, nj, nk, ba, bb, bc);
        @(negedge clk);
        start  = 1'b1;
        num_i  = NW'(ni);
        num_j  = NW'(nj);
        num_k  = NW'(nk);
        base_a = ba;
        base_b = bb;
        base_c = bc;
        t0     = cyc + 1;
        @(negedge clk);
        start  = 1'b0;
        num_i  = NW'($urandom);
        num_j  = NW'($urandom);
        num_k  = NW'($urandom);
        base_a = $urandom;
        base_b = $urandom;
        base_c = $urandom;
        check({name, "_busy_after_start"}, busy, 1);
        seen = 1'b0;
        dc   = 0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            if (done) begin
                seen = 1'b1;
                dc   = cyc + 1;
            end else begin
                @(negedge clk);
            end
        end
        check({name, "_done_seen"}, seen, 1);
        exp_dc = zero ? t0 + 2 : t0 + ni * nj * (nk * (1 + lat) + 1 + stall) + 1;
        check({name, "_done_cycle"}, dc, exp_dc);
        @(negedge clk);
        check({name, "_done_pulse"}, done, 0);
        check({name, "_busy_fall"}, busy, 0);
        check({name, "_rd_count"}, rd_seen, ni * nj * nk);
        check({name, "_wr_count"}, wr_seen, ni * nj);
        check({name, "_wr_left"}, exp_wr.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [79:0] s8;
    logic [7:0]  exp8;
    bit          seen8;
    int          ri, rj, rk;
    logic [31:0] rba, rbb, rbc;

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        start8 = 1'b0;
        num_i  = '0;
        num_j  = '0;
        num_k  = '0;
        base_a = '0;
        base_b = '0;
        base_c = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        // 2x2 directed product, 1-cycle reads, no write stalls.
        for (int n = 0; n < 4; n++) begin
            load(32'h100, n, 32'(n + 1));
            load(32'h200, n, 32'(n + 5));
        end
        do_run("m2x2", 2, 2, 2, 32'h100, 32'h200, 32'h300, 1, 0);

        // Non-square with A wrapping through the top of the address space.
        for (int n = 0; n < 6; n++) load(32'hFFFF_FFF8, n, (n < 3) ? 32'd1 : 32'd2);
        for (int n = 0; n < 3; n++) load(32'h400, n, 32'(n + 3));
        do_run("nonsq", 2, 1, 3, 32'hFFFF_FFF8, 32'h400, 32'h500, 1, 0);

        // Read latency 3 and two stall cycles per write.
        do_run("stall", 2, 2, 2, 32'h100, 32'h200, 32'h300, 3, 2);

        // Zero dimension: no traffic, done two cycles after start.
        do_run("zero_j", 2, 0, 2, 32'h100, 32'h200, 32'h300, 1, 0);

        // Abort during the third WAIT, with a read response still in flight.
        exp_rd.delete();
        exp_wr.delete();
        rd_lat  = 3;
        wr_stall = 0;
        rd_seen = 0;
        build_model(2, 2, 2, 32'h100, 32'h200, 32'h300);
        @(negedge clk);
        start  = 1'b1;
        num_i  = 16'd2;
        num_j  = 16'd2;
        num_k  = 16'd2;
        base_a = 32'h100;
        base_b = 32'h200;
        base_c = 32'h300;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && rd_seen < 3; c++) @(negedge clk);
        check("abort_third_read", rd_seen, 3);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        exp_rd.delete();
        exp_wr.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_idle_busy", busy, 0);
        check("abort_idle_wr_data", wr_data, 0);
        do_run("after_abort", 2, 2, 2, 32'h100, 32'h200, 32'h300, 1, 0);

        // 8-bit overflow: 200*2 + 200*2 = 800.
        mem8[32'h10] = 8'd200;
        mem8[32'h11] = 8'd200;
        mem8[32'h20] = 8'd2;
        mem8[32'h21] = 8'd2;
        s8 = 80'(rd_mem8(32'h10)) * 80'(rd_mem8(32'h20)) + 80'(rd_mem8(32'h11)) * 80'(rd_mem8(32'h21));
`ifdef MATMUL_SAT_EN
        exp8 = (s8 > 80'd255) ? 8'd255 : s8[7:0];
`else
        exp8 = s8[7:0];
`endif
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        seen8  = 1'b0;
        for (int c = 0; c < 200 && !seen8; c++) begin
            if (done8) seen8 = 1'b1;
            else @(negedge clk);
        end
        check("ovf_done_seen", seen8, 1);
        check("ovf_wr_count", wr_cnt8, 1);
        check("ovf_wr_addr", got8_addr, 32'h30);
        check("ovf_wr_data", got8, exp8);

        // Random products, latencies and stalls.
        for (int r = 0; r < 4; r++) begin
            ri  = $urandom_range(1, 3);
            rj  = $urandom_range(1, 3);
            rk  = $urandom_range(1, 3);
            rba = $urandom & 32'hFFFF_FFFC;
            rbb = $urandom & 32'hFFFF_FFFC;
            rbc = $urandom & 32'hFFFF_FFFC;
            for (int n = 0; n < ri * rk; n++) load(rba, n, $urandom);
            for (int n = 0; n < rk * rj; n++) load(rbb, n, $urandom);
            do_run($sformatf("rand%0d", r), ri, rj, rk, rba, rbb, rbc,
                   $urandom_range(1, 4), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_seq.md
# matmul_seq

Parametrised sequencer/datapath for unsigned matrix product C = A × B. A is num_i × num_k, B is num_k × num_j and C is num_i × num_j, all stored row-major in word-addressed memory. It walks the i/j/k loop nest in hardware, issues paired A/B reads, and accumulates each C[i][j] in a private register across k. It writes every C element exactly once, under a start/done handshake. It replaces the single-iteration datapath, which wrote a partial sum on every k step and relied on external loop control.

## Interface
- DATA_W, 32: element width in bits; must be a multiple of 8.
- ADDR_W, 32: byte-address width.
- DIM_W, 16: width of each dimension input.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a product; sampled only in IDLE.
- num_i, num_j, num_k  in  DIM_W each  dimensions; latched on start.
- base_a, base_b, base_c  in  ADDR_W each  byte base addresses; latched on start.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse when the product is complete.
- rd_en  out  1  one-cycle read request.
- rd_addr_a, rd_addr_b  out  ADDR_W each  addresses of A[i][k] and B[k][j].
- rd_valid  in  1  read response; qualifies rd_data_a and rd_data_b. Latency is at least 1 cycle.
- rd_data_a, rd_data_b  in  DATA_W each  read data.
- wr_en  out  1  write request; held until accepted.
- wr_addr  out  ADDR_W  address of C[i][j].
- wr_data  out  DATA_W  result element.
- wr_ready  in  1  write accepted when wr_en && wr_ready.

## Operation
- States: IDLE, FETCH, WAIT, WRITE, DONE.
- IDLE:
  - On start, latch the dimensions and bases and clear i, j, k and acc.
  - If any dimension is 0, go to DONE. Otherwise go to FETCH.
- FETCH:
  - Assert rd_en for one cycle with the addresses for the current i, j, k.
  - Go to WAIT.
- WAIT:
  - Hold until rd_valid.
  - On rd_valid, set acc += rd_data_a × rd_data_b.
  - If k == num_k−1, clear k and go to WRITE. Otherwise increment k and go to FETCH.
  - rd_valid outside WAIT is ignored.
- WRITE:
  - Drive wr_en, wr_addr and wr_data until wr_ready.
  - On the handshake, clear acc.
  - If j < num_j−1, increment j and go to FETCH.
  - Else clear j. If i < num_i−1, increment i and go to FETCH. Else go to DONE.
- DONE: assert done for one cycle, then go to IDLE.
- Addresses:
  - rd_addr_a = base_a + ((i·num_k + k) << log2(DATA_W/8)).
  - rd_addr_b = base_b + ((k·num_j + j) << log2(DATA_W/8)).
  - wr_addr = base_c + ((i·num_j + j) << log2(DATA_W/8)).
  - All address arithmetic is modulo 2^ADDR_W.
- Accumulator width is 2·DATA_W + DIM_W, so it never overflows internally.
- wr_data is reduced from acc to DATA_W as described under Configuration.
- start while busy is ignored. Dimension and base inputs may change freely while busy.

## Timing
- Reset values: state = IDLE; busy, done, rd_en and wr_en = 0; all address outputs, wr_data, i, j, k and acc = 0.
- Reset asserted mid-operation aborts immediately. No further rd_en or wr_en is issued, and any in-flight rd_valid is ignored after reset release.
- start sampled high at edge T gives busy = 1 and FETCH from T+1.
- Each k step takes 1 FETCH cycle plus the read latency.
- Each C element adds 1 WRITE cycle plus wr_ready stall cycles.
- With 1-cycle read latency and wr_ready tied high, done is high at cycle T + num_i·num_j·(2·num_k+1) + 1.
- A zero dimension gives done at T+2 with no memory traffic.
- busy falls in the cycle after the done pulse. start may be accepted in that same cycle.

## Configuration
- MATMUL_SAT_EN defined: wr_data = min(acc, 2^DATA_W−1), i.e. unsigned saturation.
- MATMUL_SAT_EN undefined: wr_data = acc[DATA_W−1:0], i.e. wrap-around.

## Structure
- Package matmul_pkg holds the state enum, the accumulator-width constant function, and the byte-shift constant derived from DATA_W.
- Sub-module matmul_agu: combinational address generator. It takes i, j, k, the latched dimensions and the bases, and produces the three addresses.
- The FSM, loop counters and accumulator stay in matmul_seq.

## Test plan
- 2×2 case: A=[[1,2],[3,4]], B=[[5,6],[7,8]], 1-cycle memory latency, wr_ready = 1.
  - Writes must be 19, 22, 43, 50 to base_c+0, +4, +8, +12, in that order.
  - done must be high at T+21.
- Non-square case: num_i=2, num_k=3, num_j=1, A=[[1,1,1],[2,2,2]], B=[[3],[4],[5]].
  - Writes must be 12 then 24.
  - rd_addr_b must step by 4 per k.
- Stalls: 3-cycle read latency and wr_ready low for 2 cycles per write on the 2×2 case.
  - Write data must be unchanged from the 2×2 case.
  - wr_en must be held stable throughout each stall.
- Overflow with DATA_W=8: num_k=2, A=[[200,200]], B=[[2],[2]], giving acc = 800.
  - With MATMUL_SAT_EN, wr_data must be 255.
  - Without it, wr_data must be 32.
- num_j = 0: done must be at T+2, with no rd_en and no wr_en ever asserted.
- Abort: assert reset during the third WAIT of the 2×2 case.
  - All outputs must be 0 immediately.
  - A later start must produce the correct full result.
